// File: rtl/ieee_pkg.sv
// Shared definitions for the IEEE-754 single-precision conversion blocks:
// field widths, flag positions, FSM states and operand classification.
package ieee_pkg;

  localparam int EXP_BIAS    = 127;
  localparam int MANT_W      = 23;
  localparam int INT_EXP_MAX = 158;
  localparam int ALIGN_EXP   = 150;

  localparam int FLAG_INEXACT  = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_W        = 3;

  localparam logic [31:0] INT_POS_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_NEG_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_NAN,
    CLS_INF,
    CLS_ZERO_OR_SMALL,
    CLS_OVERFLOW,
    CLS_EXACT_MIN,
    CLS_NORMAL
  } fclass_t;

  // Decoded operand, ready for the alignment shifter.
  typedef struct packed {
    logic              sign;
    fclass_t           cls;
    logic [MANT_W-1:0] mant;
    logic [4:0]        shift_n;
    logic              shift_left;
  } unpack_t;

  function automatic logic [FLAG_W-1:0] make_flags(input logic inexact,
                                                   input logic overflow,
                                                   input logic invalid);
    logic [FLAG_W-1:0] f;
    f                = '0;
    f[FLAG_INEXACT]  = inexact;
    f[FLAG_OVERFLOW] = overflow;
    f[FLAG_INVALID]  = invalid;
    return f;
  endfunction

  function automatic logic [31:0] apply_sign(input logic sign, input logic [31:0] mag);
    return sign ? (~mag + 32'd1) : mag;
  endfunction

endpackage

// File: rtl/ieee_unpack.sv
// Combinational field split and classification of an IEEE-754 single,
// including the alignment shift count and direction toward a 2^0 LSB.
module ieee_unpack
  import ieee_pkg::*;
(
  input  logic [31:0] in_float,
  output unpack_t     unpacked
);

  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;
  localparam logic [7:0] EXP_BIAS_E   = 8'(EXP_BIAS);
  localparam logic [7:0] EXP_MAX_E    = 8'(INT_EXP_MAX);
  localparam logic [7:0] EXP_ALIGN_E  = 8'(ALIGN_EXP);

  logic [7:0]        exp_field;
  logic [MANT_W-1:0] mant_field;
  logic [7:0]        exp_diff;

  assign exp_field  = in_float[30:23];
  assign mant_field = in_float[MANT_W-1:0];

  always_comb begin
    // NOTE: every output gets a default up front so no path through the
    // if/else chain can leave a field unassigned and infer a latch.
    unpacked.sign       = in_float[31];
    unpacked.mant       = mant_field;
    unpacked.cls        = CLS_NORMAL;
    unpacked.shift_n    = '0;
    unpacked.shift_left = 1'b0;
    exp_diff            = '0;

    if (exp_field == EXP_ALL_ONES) begin
      unpacked.cls = (mant_field != '0) ? CLS_NAN : CLS_INF;
    end else if (exp_field < EXP_BIAS_E) begin
      unpacked.cls = CLS_ZERO_OR_SMALL;
    end else if (exp_field >= EXP_MAX_E) begin
      // -2^31 is the single out-of-range-looking value that is representable.
      if (in_float[31] && exp_field == EXP_MAX_E && mant_field == '0)
        unpacked.cls = CLS_EXACT_MIN;
      else
        unpacked.cls = CLS_OVERFLOW;
    end else begin
      unpacked.cls = CLS_NORMAL;
      if (exp_field > EXP_ALIGN_E) begin
        exp_diff            = exp_field - EXP_ALIGN_E;
        unpacked.shift_left = 1'b1;
      end else begin
        exp_diff            = EXP_ALIGN_E - exp_field;
        unpacked.shift_left = 1'b0;
      end
      unpacked.shift_n = exp_diff[4:0];
    end
  end

endmodule

// File: rtl/ieee_to_int32.sv
// Multi-cycle IEEE-754 single to signed int32 converter, round toward zero,
// with valid/ready on both sides and a one-bit-per-cycle alignment shifter.
module ieee_to_int32
  import ieee_pkg::*;
#(
  parameter logic [31:0] NAN_VALUE = 32'h7FFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_float,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_int,
  output logic [FLAG_W-1:0] out_flags
);

  state_t      state;
  unpack_t     unpacked;
  logic [31:0] mag;
  logic [4:0]  n;
  logic        dir_left;
  logic        sticky;
  logic        sign_q;

  logic [31:0] mag_load;
  logic [31:0] mag_next;
  logic        sticky_next;

  ieee_unpack u_unpack (
    .in_float (in_float),
    .unpacked (unpacked)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign mag_load  = {8'b0, 1'b1, unpacked.mant};

  always_comb begin
    mag_next    = mag;
    sticky_next = sticky;
    if (dir_left) begin
      mag_next = {mag[30:0], 1'b0};
    end else begin
      mag_next    = {1'b0, mag[31:1]};
      sticky_next = sticky | mag[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      mag       <= '0;
      n         <= '0;
      dir_left  <= 1'b0;
      sticky    <= 1'b0;
      sign_q    <= 1'b0;
      out_int   <= '0;
      out_flags <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= unpacked.sign;
            sticky <= 1'b0;
            unique case (unpacked.cls)
              CLS_NAN: begin
                out_int   <= NAN_VALUE;
                out_flags <= make_flags(1'b0, 1'b0, 1'b1);
                state     <= DONE;
              end
              CLS_INF: begin
                out_int   <= unpacked.sign ? INT_NEG_MIN : INT_POS_MAX;
                out_flags <= make_flags(1'b0, 1'b0, 1'b1);
                state     <= DONE;
              end
              CLS_ZERO_OR_SMALL: begin
                out_int   <= '0;
                out_flags <= make_flags(in_float[30:0] != '0, 1'b0, 1'b0);
                state     <= DONE;
              end
              CLS_EXACT_MIN: begin
                out_int   <= INT_NEG_MIN;
                out_flags <= '0;
                state     <= DONE;
              end
              CLS_OVERFLOW: begin
                out_int   <= unpacked.sign ? INT_NEG_MIN : INT_POS_MAX;
                out_flags <= make_flags(1'b0, 1'b1, 1'b0);
                state     <= DONE;
              end
              default: begin
                mag      <= mag_load;
                n        <= unpacked.shift_n;
                dir_left <= unpacked.shift_left;
                if (unpacked.shift_n == '0) begin
                  out_int   <= apply_sign(unpacked.sign, mag_load);
                  out_flags <= '0;
                  state     <= DONE;
                end else begin
                  state <= SHIFT;
                end
              end
            endcase
          end
        end

        SHIFT: begin
          mag    <= mag_next;
          sticky <= sticky_next;
          n      <= n - 5'd1;
          // Last shift: publish the aligned, signed result in the same edge.
          if (n == 5'd1) begin
            out_int   <= apply_sign(sign_q, mag_next);
            out_flags <= make_flags(sticky_next, 1'b0, 1'b0);
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ieee_to_int32.sv
// Self-checking bench for ieee_to_int32: behavioural float-to-int model with a
// scoreboard, per-cycle output compare, directed vectors and handshake cases.
module tb_ieee_to_int32;

  localparam logic [31:0] NAN_VALUE = 32'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_float = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_int;
  logic [2:0]  out_flags;

  ieee_to_int32 #(.NAN_VALUE(NAN_VALUE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_float  (in_float),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   lat_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Value-level model: exact real-number truncation of (-1)^s * 1.m * 2^(e-127).
  function automatic exp_t model(input logic [31:0] f);
    exp_t   x;
    logic   s;
    int     e;
    int     sh;
    longint sig;
    longint mag;
    logic   inx;
    s     = f[31];
    e     = int'(f[30:23]);
    sig   = longint'({1'b1, f[22:0]});
    x.lat = 0;
    x.acc = 0;
    x.r   = '0;
    x.f   = '0;
    if (e == 255) begin
      x.r = (f[22:0] != 0) ? NAN_VALUE : (s ? 32'h8000_0000 : 32'h7FFF_FFFF);
      x.f = 3'b100;
    end else if (e < 127) begin
      x.r = '0;
      x.f = {2'b00, f[30:0] != 0};
    end else if (e >= 158) begin
      if (s && e == 158 && f[22:0] == 0) begin
        x.r = 32'h8000_0000;
        x.f = 3'b000;
      end else begin
        x.r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        x.f = 3'b010;
      end
    end else begin
      sh = e - 150;
      if (sh >= 0) begin
        mag = sig << sh;
        inx = 1'b0;
      end else begin
        mag = sig >> (-sh);
        inx = (sig & ((64'd1 << (-sh)) - 64'd1)) != 0;
      end
      x.r   = s ? 32'(-mag) : 32'(mag);
      x.f   = {2'b00, inx};
      x.lat = (sh < 0) ? -sh : sh;
    end
    return x;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Accept / retire monitor feeding the scoreboard.
  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_t e;
        e     = model(in_float);
        e.acc = cyc;
        exp_q.push_back(e);
      end
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  // Compare process: every cycle out_valid is high the outputs must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid: got out_int=%h with no accepted operand", out_int);
        end else begin
          check("model_out_int", out_int, exp_q[0].r);
          check("model_out_flags", {29'b0, out_flags}, {29'b0, exp_q[0].f});
          if (!lat_done) begin
            check("model_latency", 32'(cyc - exp_q[0].acc - 1), 32'(exp_q[0].lat));
            lat_done = 1'b1;
          end
        end
      end else begin
        lat_done = 1'b0;
      end
    end
  end

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: out_valid still low after %0d cycles", name, n);
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic convert(input logic [31:0] f, input logic [31:0] lit_r,
                         input logic [2:0] lit_f, input int hold);
    @(negedge clk);
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_float = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    wait_out_valid("convert");
    check("lit_out_int", out_int, lit_r);
    check("lit_out_flags", {29'b0, out_flags}, {29'b0, lit_f});
    repeat (hold) begin
      @(negedge clk);
      check("held_in_ready", {31'b0, in_ready}, 32'd0);
      check("held_out_valid", {31'b0, out_valid}, 32'd1);
      check("held_out_int", out_int, lit_r);
    end
    take_result();
    @(negedge clk);
    check("in_ready_after", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_int", out_int, 32'd0);
    check("rst_out_flags", {29'b0, out_flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert(32'h3FC0_0000, 32'h0000_0001, 3'b001, 0);
    convert(32'hC2F6_0000, 32'hFFFF_FF85, 3'b000, 5);
    convert(32'h4B80_0000, 32'h0100_0000, 3'b000, 0);
    convert(32'h4B00_0000, 32'h0080_0000, 3'b000, 0);
    convert(32'hCF00_0000, 32'h8000_0000, 3'b000, 0);
    convert(32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 0);
    convert(32'h7FC0_0000, NAN_VALUE,     3'b100, 0);
    convert(32'hFF80_0000, 32'h8000_0000, 3'b100, 0);
    convert(32'h0000_0001, 32'h0000_0000, 3'b001, 0);
    convert(32'h8000_0000, 32'h0000_0000, 3'b000, 0);
    convert(32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 0);
    convert(32'hBF7F_FFFF, 32'h0000_0000, 3'b001, 0);

    // Second operand presented during SHIFT must wait for the first result.
    @(negedge clk);
    in_float = 32'h3FC0_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_float = 32'h42F6_0000;
    repeat (10) begin
      @(negedge clk);
      check("shift_in_ready", {31'b0, in_ready}, 32'd0);
    end
    check("shift_one_accepted", 32'(exp_q.size()), 32'd1);
    wait_out_valid("first_of_pair");
    check("pair_first_int", out_int, 32'h0000_0001);
    take_result();
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    wait_out_valid("second_of_pair");
    check("pair_second_int", out_int, 32'h0000_007B);
    take_result();

    // Reset mid-SHIFT aborts the operation.
    @(negedge clk);
    in_float = 32'h3FC0_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      check("abort_no_result", {31'b0, out_valid}, 32'd0);
    end
    convert(32'h4000_0000, 32'h0000_0002, 3'b000, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
